// File: rtl/dmem_dual_arbiter.sv
// dmem_dual_arbiter
//   Shares one single-port data memory between two pipelined cores. One access
//   is granted per cycle. When both cores request, a round-robin pointer picks
//   the winner and then toggles. The losing core is stalled combinationally in
//   the same cycle, and load data is returned one cycle after the grant.
//   Optional feature macro: DMEM_ARB_STATS_EN builds a saturating counter of
//   contended cycles. Without it, conflict_cnt_o is tied to zero.
module dmem_dual_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    // core 0
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    input  logic              p0_read_i,
    input  logic              p0_write_i,
    output logic              p0_stall_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    output logic              p0_rvalid_o,
    // core 1
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    input  logic              p1_read_i,
    input  logic              p1_write_i,
    output logic              p1_stall_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              p1_rvalid_o,
    // shared memory
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // statistics
    output logic [31:0]       conflict_cnt_o
);

    localparam int NP = 2;

    // Per-port views of the request ports, indexed by port number
    logic [NP-1:0]     rd_req;
    logic [NP-1:0]     wr_req;
    logic [NP-1:0]     req;
    logic [NP-1:0]     grant;
    logic [NP-1:0]     stall;
    logic [NP-1:0]     ret_hit;
    logic [ADDR_W-1:0] port_addr  [NP];
    logic [DATA_W-1:0] port_wdata [NP];
    logic [DATA_W-1:0] port_rdata [NP];

    // Arbitration state
    logic contended;
    logic any_req;
    logic win_id;
    logic rr_ptr_q;
    logic rr_ptr_d;
    logic rd_pend_q;
    logic rd_pend_d;
    logic rd_id_q;
    logic rd_id_d;

    assign rd_req        = {p1_read_i, p0_read_i};
    assign wr_req        = {p1_write_i, p0_write_i};
    assign port_addr[0]  = p0_addr_i;
    assign port_addr[1]  = p1_addr_i;
    assign port_wdata[0] = p0_wdata_i;
    assign port_wdata[1] = p1_wdata_i;

    // Pick the winning port: a sole requester wins, otherwise the round-robin pointer decides
    always_comb begin
        contended = &req;
        any_req   = |req;
        win_id    = 1'b0;
        if (contended) begin
            win_id = rr_ptr_q;
        end else if (req[1]) begin
            win_id = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_q;
            logic [DATA_W-1:0] rdata_d;

            // A write with a simultaneous read is treated as a plain write
            assign req[gi]     = rd_req[gi] | wr_req[gi];
            assign grant[gi]   = any_req & (win_id == 1'(gi));
            assign stall[gi]   = req[gi] & ~grant[gi];
            assign ret_hit[gi] = rd_pend_q & (rd_id_q == 1'(gi));

            // Pass returning load data straight through, and hold it once the return is over
            always_comb begin
                rdata_d = rdata_q;
                if (ret_hit[gi]) begin
                    rdata_d = mem_rdata_i;
                end
            end

            // Holding register for the last load data delivered to this port
            always_ff @(posedge clk_i) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign port_rdata[gi] = rdata_d;
        end
    endgenerate

    // Route the winner's request to memory; an idle cycle drives all zeros
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        if (any_req) begin
            mem_addr_o  = port_addr[win_id];
            mem_wdata_o = port_wdata[win_id];
            mem_write_o = wr_req[win_id];
            mem_read_o  = rd_req[win_id] & ~wr_req[win_id];
        end
    end

    // Next state: toggle priority only on contention, and remember who owns the load in flight
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rd_pend_d = mem_read_o;
        rd_id_d   = rd_id_q;
        if (contended) begin
            rr_ptr_d = ~rr_ptr_q;
        end
        if (mem_read_o) begin
            rd_id_d = win_id;
        end
    end

    // Arbitration registers; a load granted while reset is sampled is discarded
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rr_ptr_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] conflict_cnt_q;
    logic [31:0] conflict_cnt_d;

    // Count contended cycles, sticking at all-ones instead of wrapping
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (contended && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    // Contention counter register
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_cnt_o = '0;
`endif

    assign p0_stall_o  = stall[0];
    assign p1_stall_o  = stall[1];
    assign p0_rvalid_o = ret_hit[0];
    assign p1_rvalid_o = ret_hit[1];
    assign p0_rdata_o  = port_rdata[0];
    assign p1_rdata_o  = port_rdata[1];

endmodule

// File: tb/tb_dmem_dual_arbiter.sv
// tb_dmem_dual_arbiter
//   Directed scenarios plus a randomized run of two agents that hold their
//   requests while stalled. A transaction-level model (memory array, favoured
//   port, pending returns) predicts grants, memory traffic and load returns.
`timescale 1ns/1ps
module tb_dmem_dual_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
    logic        p0_read_i, p0_write_i, p1_read_i, p1_write_i;
    logic        p0_stall_o, p1_stall_o, p0_rvalid_o, p1_rvalid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_read_o, mem_write_o;
    logic [31:0] conflict_cnt_o;

`ifdef DMEM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    dmem_dual_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i), .p0_read_i(p0_read_i),
        .p0_write_i(p0_write_i), .p0_stall_o(p0_stall_o), .p0_rdata_o(p0_rdata_o),
        .p0_rvalid_o(p0_rvalid_o),
        .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i), .p1_read_i(p1_read_i),
        .p1_write_i(p1_write_i), .p1_stall_o(p1_stall_o), .p1_rdata_o(p1_rdata_o),
        .p1_rvalid_o(p1_rvalid_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata_i),
        .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory fixture: 16 words, synchronous write, registered read
    logic [31:0] ram [16];
    bit          clear_ram;
    always @(posedge clk_i) begin
        if (clear_ram) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else if (mem_write_o) begin
            ram[mem_addr_o[5:2]] <= mem_wdata_o;
        end
        if (mem_read_o) mem_rdata_i <= ram[mem_addr_o[5:2]];
    end

    // Reference model
    logic [31:0] m_mem [16];
    bit          m_favour;
    bit   [1:0]  m_ret_v;
    logic [31:0] m_ret_d [2];
    logic [31:0] m_last  [2];
    logic [31:0] m_conf;

    // Expectations for the current cycle
    int          exp_win;
    bit   [1:0]  exp_stall;
    bit   [1:0]  exp_rv;
    logic [31:0] exp_rd [2];
    logic [65:0] exp_mem;
    logic [31:0] exp_cnt;
    bit          cur_rstn;
    bit   [1:0]  cur_rd, cur_wr;
    logic [31:0] cur_a [2];
    logic [31:0] cur_d [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Apply one cycle of requests and predict everything visible during it
    task automatic drive_cycle(input bit rstn, input bit r0, input bit w0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input bit r1, input bit w1,
                               input logic [31:0] a1, input logic [31:0] d1);
        bit q0, q1;
        rst_n = rstn;
        p0_read_i = r0; p0_write_i = w0; p0_addr_i = a0; p0_wdata_i = d0;
        p1_read_i = r1; p1_write_i = w1; p1_addr_i = a1; p1_wdata_i = d1;
        cur_rstn = rstn; cur_rd = {r1, r0}; cur_wr = {w1, w0};
        cur_a[0] = a0; cur_a[1] = a1; cur_d[0] = d0; cur_d[1] = d1;
        q0 = r0 | w0;
        q1 = r1 | w1;
        if (q0 && q1)  exp_win = m_favour ? 1 : 0;
        else if (q0)   exp_win = 0;
        else if (q1)   exp_win = 1;
        else           exp_win = -1;
        exp_stall = {q1 && (exp_win != 1), q0 && (exp_win != 0)};
        if (exp_win < 0) exp_mem = '0;
        else exp_mem = {cur_a[exp_win], cur_d[exp_win],
                        cur_rd[exp_win] & ~cur_wr[exp_win], cur_wr[exp_win]};
        exp_rv = m_ret_v;
        for (int p = 0; p < 2; p++) exp_rd[p] = m_ret_v[p] ? m_ret_d[p] : m_last[p];
        exp_cnt = STATS ? m_conf : 32'd0;
        @(negedge clk_i);
    endtask

    // Close the cycle at the rising edge and advance the model
    task automatic finish_cycle();
        int idx;
        @(posedge clk_i);
        for (int p = 0; p < 2; p++) if (m_ret_v[p]) m_last[p] = m_ret_d[p];
        m_ret_v = '0;
        if (exp_win >= 0) begin
            idx = int'(cur_a[exp_win][5:2]);
            $display("[%0t] grant p%0d %s addr=0x%0h wdata=0x%0h", $time, exp_win,
                     cur_wr[exp_win] ? "WR" : "RD", cur_a[exp_win], cur_d[exp_win]);
            if (cur_wr[exp_win]) begin
                m_mem[idx] = cur_d[exp_win];
            end else begin
                m_ret_v[exp_win] = 1'b1;
                m_ret_d[exp_win] = m_mem[idx];
            end
        end
        if ((cur_rd | cur_wr) == 2'b11) begin
            m_favour = (exp_win == 0);
            if (m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 32'd1;
        end
        if (!cur_rstn) begin
            m_favour = 1'b0; m_ret_v = '0; m_conf = '0;
            m_last[0] = '0; m_last[1] = '0;
        end
        #1;
    endtask

    task automatic idle_cycle(input bit rstn);
        drive_cycle(rstn, 0, 0, 0, 0, 0, 0, 0, 0);
        finish_cycle();
    endtask

    task automatic do_reset();
        idle_cycle(1'b0);
        idle_cycle(1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if ({p1_stall_o, p0_stall_o} !== 2'b00) $display("FAIL rst_stall got=%b exp=00", {p1_stall_o, p0_stall_o}); else n_pass++;
        n_checks++; if ({mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o} !== 66'd0) $display("FAIL rst_mem got=%h exp=0", {mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o}); else n_pass++;
        n_checks++; if ({p1_rvalid_o, p0_rvalid_o} !== 2'b00) $display("FAIL rst_rvalid got=%b exp=00", {p1_rvalid_o, p0_rvalid_o}); else n_pass++;
        n_checks++; if ({p1_rdata_o, p0_rdata_o} !== 64'd0) $display("FAIL rst_rdata got=%h exp=0", {p1_rdata_o, p0_rdata_o}); else n_pass++;
        n_checks++; if (conflict_cnt_o !== 32'd0) $display("FAIL rst_cnt got=%0d exp=0", conflict_cnt_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 1, 0, 32'd4, 0, 1, 0, 32'd12, 0);
        n_checks++; if ({p1_stall_o, p0_stall_o} !== 2'b10) $display("FAIL rst_first_grant_stall got=%b exp=10", {p1_stall_o, p0_stall_o}); else n_pass++;
        n_checks++; if (mem_addr_o !== 32'd4 || mem_read_o !== 1'b1) $display("FAIL rst_first_grant_addr got=%0d/%b exp=4/1", mem_addr_o, mem_read_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 1, 0, 32'd12, 0);
        n_checks++; if (p1_stall_o !== 1'b0 || mem_addr_o !== 32'd12) $display("FAIL rst_held_grant got=%b/%0d exp=0/12", p1_stall_o, mem_addr_o); else n_pass++;
        finish_cycle();
        idle_cycle(1'b1);
        idle_cycle(1'b1);
    endtask

    task automatic test_write_then_read();
        drive_cycle(1, 0, 1, 32'd8, 32'd7, 0, 0, 0, 0);
        n_checks++; if (mem_write_o !== 1'b1 || mem_addr_o !== 32'd8 || mem_wdata_o !== 32'd7) $display("FAIL wr_mem got=%b/%0d/%0d exp=1/8/7", mem_write_o, mem_addr_o, mem_wdata_o); else n_pass++;
        n_checks++; if (p0_stall_o !== 1'b0) $display("FAIL wr_stall got=%b exp=0", p0_stall_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 1, 0, 32'd8, 0, 0, 0, 0, 0);
        n_checks++; if (mem_read_o !== 1'b1 || mem_write_o !== 1'b0) $display("FAIL rd_mem got=%b%b exp=10", mem_read_o, mem_write_o); else n_pass++;
        n_checks++; if (p0_rvalid_o !== 1'b0) $display("FAIL rd_early_rvalid got=%b exp=0", p0_rvalid_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'd7) $display("FAIL rd_return got=%b/%0d exp=1/7", p0_rvalid_o, p0_rdata_o); else n_pass++;
        n_checks++; if (p1_rvalid_o !== 1'b0) $display("FAIL rd_other_rvalid got=%b exp=0", p1_rvalid_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (p0_rvalid_o !== 1'b0 || p0_rdata_o !== 32'd7) $display("FAIL rd_hold got=%b/%0d exp=0/7", p0_rvalid_o, p0_rdata_o); else n_pass++;
        finish_cycle();
    endtask

    task automatic test_both_read();
        drive_cycle(1, 0, 1, 32'd4, 32'hA5, 0, 0, 0, 0); finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 0, 1, 32'd12, 32'h5A); finish_cycle();
        do_reset();
        drive_cycle(1, 1, 0, 32'd4, 0, 1, 0, 32'd12, 0);
        n_checks++; if ({p1_stall_o, p0_stall_o} !== 2'b10 || mem_addr_o !== 32'd4) $display("FAIL both_c1 got=%b/%0d exp=10/4", {p1_stall_o, p0_stall_o}, mem_addr_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 1, 0, 32'd12, 0);
        n_checks++; if (p1_stall_o !== 1'b0 || mem_addr_o !== 32'd12) $display("FAIL both_c2_grant got=%b/%0d exp=0/12", p1_stall_o, mem_addr_o); else n_pass++;
        n_checks++; if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'hA5) $display("FAIL both_c2_p0data got=%b/%h exp=1/a5", p0_rvalid_o, p0_rdata_o); else n_pass++;
        n_checks++; if (conflict_cnt_o !== (STATS ? 32'd1 : 32'd0)) $display("FAIL both_cnt got=%0d exp=%0d", conflict_cnt_o, STATS ? 1 : 0); else n_pass++;
        finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (p1_rvalid_o !== 1'b1 || p1_rdata_o !== 32'h5A || p0_rvalid_o !== 1'b0) $display("FAIL both_c3_p1data got=%b/%h/%b exp=1/5a/0", p1_rvalid_o, p1_rdata_o, p0_rvalid_o); else n_pass++;
        finish_cycle();
    endtask

    task automatic test_alternate();
        int run0, run1;
        run0 = 0; run1 = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 1, 0, 32'd20, 0, 1, 0, 32'd24, 0);
            n_checks++; if (mem_addr_o !== ((i % 2 == 0) ? 32'd20 : 32'd24)) $display("FAIL alt_addr cyc=%0d got=%0d exp=%0d", i, mem_addr_o, (i % 2 == 0) ? 20 : 24); else n_pass++;
            n_checks++; if ({p1_stall_o, p0_stall_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL alt_stall cyc=%0d got=%b", i, {p1_stall_o, p0_stall_o}); else n_pass++;
            run0 = p0_stall_o ? run0 + 1 : 0;
            run1 = p1_stall_o ? run1 + 1 : 0;
            n_checks++; if (run0 > 1 || run1 > 1) $display("FAIL alt_starve cyc=%0d got=%0d/%0d exp<=1", i, run0, run1); else n_pass++;
            finish_cycle();
        end
        idle_cycle(1'b1);
        idle_cycle(1'b1);
    endtask

    task automatic test_same_addr();
        do_reset();
        drive_cycle(1, 1, 0, 32'd0, 0, 1, 0, 32'd0, 0); finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 1, 0, 32'd0, 0); finish_cycle();
        drive_cycle(1, 1, 0, 32'd16, 0, 0, 1, 32'd16, 32'd5);
        n_checks++; if (p0_stall_o !== 1'b1 || p1_stall_o !== 1'b0 || mem_write_o !== 1'b1 || mem_addr_o !== 32'd16) $display("FAIL same_wr_first got=%b%b/%b/%0d exp=10/1/16", p0_stall_o, p1_stall_o, mem_write_o, mem_addr_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 1, 0, 32'd16, 0, 0, 0, 0, 0);
        n_checks++; if (p0_stall_o !== 1'b0 || mem_read_o !== 1'b1) $display("FAIL same_rd_second got=%b/%b exp=0/1", p0_stall_o, mem_read_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'd5) $display("FAIL same_rd_data got=%b/%0d exp=1/5", p0_rvalid_o, p0_rdata_o); else n_pass++;
        finish_cycle();
    endtask

    task automatic test_reset_drop();
        do_reset();
        drive_cycle(1, 1, 0, 32'd8, 0, 1, 0, 32'd8, 0); finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 1, 0, 32'd8, 0); finish_cycle();
        idle_cycle(1'b1);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (p0_rdata_o !== 32'd7) $display("FAIL drop_pre_rdata got=%0d exp=7", p0_rdata_o); else n_pass++;
        finish_cycle();
        drive_cycle(0, 1, 0, 32'd8, 0, 0, 0, 0, 0);
        n_checks++; if (mem_read_o !== 1'b1 || p0_stall_o !== 1'b0) $display("FAIL drop_grant got=%b/%b exp=1/0", mem_read_o, p0_stall_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if ({p1_rvalid_o, p0_rvalid_o} !== 2'b00) $display("FAIL drop_rvalid got=%b exp=00", {p1_rvalid_o, p0_rvalid_o}); else n_pass++;
        n_checks++; if (p0_rdata_o !== 32'd0 || p1_rdata_o !== 32'd0) $display("FAIL drop_rdata got=%0d/%0d exp=0/0", p0_rdata_o, p1_rdata_o); else n_pass++;
        finish_cycle();
        drive_cycle(1, 1, 0, 32'd8, 0, 1, 0, 32'd8, 0);
        n_checks++; if ({p1_stall_o, p0_stall_o} !== 2'b10) $display("FAIL drop_rr got=%b exp=10", {p1_stall_o, p0_stall_o}); else n_pass++;
        finish_cycle();
        drive_cycle(1, 0, 0, 0, 0, 1, 0, 32'd8, 0); finish_cycle();
        idle_cycle(1'b1);
    endtask

    task automatic test_random();
        bit          pr [2];
        bit          pw [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        bit   [1:0]  hold;
        int          op;
        hold = '0;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!hold[p]) begin
                    op = int'($urandom_range(0, 9));
                    pr[p] = (op >= 3 && op <= 5) || op == 9;
                    pw[p] = (op >= 6);
                    pa[p] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    pd[p] = $urandom;
                end
            end
            drive_cycle(1, pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1]);
            n_checks++; if ({p1_stall_o, p0_stall_o} !== exp_stall) $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, {p1_stall_o, p0_stall_o}, exp_stall); else n_pass++;
            n_checks++; if ({mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o} !== exp_mem) $display("FAIL rnd_mem cyc=%0d got=%h exp=%h", c, {mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o}, exp_mem); else n_pass++;
            n_checks++; if ({p1_rvalid_o, p0_rvalid_o} !== exp_rv) $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, {p1_rvalid_o, p0_rvalid_o}, exp_rv); else n_pass++;
            n_checks++; if (p0_rdata_o !== exp_rd[0]) $display("FAIL rnd_rdata0 cyc=%0d got=%h exp=%h", c, p0_rdata_o, exp_rd[0]); else n_pass++;
            n_checks++; if (p1_rdata_o !== exp_rd[1]) $display("FAIL rnd_rdata1 cyc=%0d got=%h exp=%h", c, p1_rdata_o, exp_rd[1]); else n_pass++;
            n_checks++; if (conflict_cnt_o !== exp_cnt) $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, conflict_cnt_o, exp_cnt); else n_pass++;
            hold = exp_stall;
            finish_cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0; clear_ram = 1'b1;
        p0_read_i = 0; p0_write_i = 0; p0_addr_i = 0; p0_wdata_i = 0;
        p1_read_i = 0; p1_write_i = 0; p1_addr_i = 0; p1_wdata_i = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_favour = 1'b0; m_ret_v = '0; m_conf = '0;
        m_last[0] = '0; m_last[1] = '0; m_ret_d[0] = '0; m_ret_d[1] = '0;
        @(posedge clk_i);
        clear_ram = 1'b0;
        #1;
        test_reset();
        test_write_then_read();
        test_both_read();
        test_alternate();
        test_same_addr();
        test_reset_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
